// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirect squash of in-flight reads, decode-latch control.
// Optional HALT detection on the all-ones word is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit #(
  parameter logic [31:0] PC0 = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] npc_o,
  output logic [31:0] instr_o,
  output logic        pipe1_en,
  output logic        flush_o,
  output logic        halted
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] HALT_WORD  = '1;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HALT   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            halted_q, halted_d;

  logic            ren;
  logic            load_en;
  logic            flush;
  logic [XLEN-1:0] target;

  // Low address bits of the redirect target are dropped to keep fetches word aligned.
  assign target = redirect_pc & ALIGN_MASK;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= FETCH;
      pc_q      <= PC0;
      pend_pc_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    halted_d  = halted_q;
    ren       = 1'b0;
    load_en   = 1'b0;
    flush     = 1'b0;

    unique case (state_q)
      FETCH: begin
        ren = 1'b1;
        if (redirect) begin
          flush = 1'b1;
          if (ihit) begin
            pc_d = target;
          end else begin
            // Read for the old pc is still outstanding; wait it out before retargeting.
            pend_pc_d = target;
            state_d   = SQUASH;
          end
        end else if (ihit && !stall) begin
          load_en = 1'b1;
          pc_d    = pc_q + WORD_BYTES;
`ifdef FETCH_HALT_DETECT_EN
          if (imemload == HALT_WORD) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
`endif
        end
      end

      SQUASH: begin
        ren = 1'b1;
        if (redirect) begin
          flush     = 1'b1;
          pend_pc_d = target;
          if (ihit) begin
            pc_d    = target;
            state_d = FETCH;
          end
        end else if (ihit) begin
          pc_d    = pend_pc_q;
          state_d = FETCH;
        end
      end

      HALT: begin
`ifdef FETCH_HALT_DETECT_EN
        if (redirect) begin
          flush    = 1'b1;
          pc_d     = target;
          state_d  = FETCH;
          halted_d = 1'b0;
        end
`else
        state_d = FETCH;
`endif
      end

      default: state_d = FETCH;
    endcase
  end

  // Handshake outputs are forced inactive while reset is asserted.
  assign imemREN  = nRST & ren;
  assign pipe1_en = nRST & load_en;
  assign flush_o  = nRST & flush;
  assign imemaddr = pc_q;
  assign npc_o    = pc_q + WORD_BYTES;
  assign instr_o  = imemload;
  assign halted   = halted_q;

  // HALT_WORD is only referenced when halt detection is built in.
  logic unused_halt_word;
  assign unused_halt_word = ^HALT_WORD;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; halt checks follow FETCH_HALT_DETECT_EN.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] npc_o;
  logic [31:0] instr_o;
  logic        pipe1_en;
  logic        flush_o;
  logic        halted;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  fetch_unit #(.PC0(32'h0000_0000)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ihit       (ihit),
    .imemload   (imemload),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .npc_o      (npc_o),
    .instr_o    (instr_o),
    .pipe1_en   (pipe1_en),
    .flush_o    (flush_o),
    .halted     (halted)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Apply one cycle of inputs and let combinational outputs settle.
  task automatic drive(input logic hit, input logic stl, input logic rd, input logic [31:0] rpc);
    ihit        = hit;
    stall       = stl;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  // Move pc to an aligned address using a redirect that hits.
  task automatic goto_pc(input logic [31:0] addr);
    drive(1'b1, 1'b0, 1'b1, addr);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  always @(negedge CLK) begin
    if (nRST) check_eq("flush_pipe_excl", {31'b0, flush_o & pipe1_en}, 32'h0);
  end

  initial begin
    nRST = 1'b0;
    imemload = 32'h1234_5678;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0500);
    #1;
    check_eq("rst_ren",    {31'b0, imemREN},  32'h0);
    check_eq("rst_addr",   imemaddr,          32'h0);
    check_eq("rst_pipe",   {31'b0, pipe1_en}, 32'h0);
    check_eq("rst_flush",  {31'b0, flush_o},  32'h0);
    check_eq("rst_npc",    npc_o,             32'h4);
    check_eq("rst_instr",  instr_o,           32'h1234_5678);
    check_eq("rst_halted", {31'b0, halted},   32'h0);

    tick();
    nRST = 1'b1;
    // Three consecutive hits from reset.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      check_eq("seq_addr", imemaddr, 32'(i * 4));
      check_eq("seq_pipe", {31'b0, pipe1_en}, 32'h1);
      check_eq("seq_npc",  npc_o, 32'((i + 1) * 4));
      check_eq("seq_ren",  {31'b0, imemREN}, 32'h1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("seq_addr_end", imemaddr, 32'hC);

    // Miss for two cycles at 0x10.
    goto_pc(32'h10);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      check_eq("miss_addr", imemaddr, 32'h10);
      check_eq("miss_pipe", {31'b0, pipe1_en}, 32'h0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("miss_hit_pipe", {31'b0, pipe1_en}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("miss_adv_addr", imemaddr, 32'h14);

    // Redirect wins over stall; low target bits ignored.
    goto_pc(32'h20);
    drive(1'b1, 1'b1, 1'b1, 32'h103);
    check_eq("rdst_flush", {31'b0, flush_o},  32'h1);
    check_eq("rdst_pipe",  {31'b0, pipe1_en}, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("rdst_addr", imemaddr, 32'h100);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check_eq("stall_pipe", {31'b0, pipe1_en}, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("stall_addr", imemaddr, 32'h100);

    // Redirect on a miss, re-redirect while squashing.
    goto_pc(32'h40);
    drive(1'b0, 1'b0, 1'b1, 32'h200);
    check_eq("sq_flush1", {31'b0, flush_o}, 32'h1);
    check_eq("sq_pipe1",  {31'b0, pipe1_en}, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h300);
    check_eq("sq_addr2",  imemaddr, 32'h40);
    check_eq("sq_flush2", {31'b0, flush_o}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("sq_addr3",  imemaddr, 32'h40);
    check_eq("sq_flush3", {31'b0, flush_o}, 32'h0);
    check_eq("sq_ren3",   {31'b0, imemREN}, 32'h1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("sq_addr4", imemaddr, 32'h40);
    check_eq("sq_pipe4", {31'b0, pipe1_en}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("sq_addr5", imemaddr, 32'h300);
    check_eq("sq_pipe5", {31'b0, pipe1_en}, 32'h1);
    tick();

    // PC wraparound.
    goto_pc(32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("wrap_npc",  npc_o, 32'h0);
    check_eq("wrap_pipe", {31'b0, pipe1_en}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("wrap_addr", imemaddr, 32'h0);

    // All-ones word at 0x8.
    goto_pc(32'h8);
    imemload = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("hw_pipe",  {31'b0, pipe1_en}, 32'h1);
    check_eq("hw_instr", instr_o, 32'hFFFF_FFFF);
    tick();
    imemload = 32'h0000_0013;
`ifdef FETCH_HALT_DETECT_EN
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("halt_halted", {31'b0, halted},   32'h1);
    check_eq("halt_ren",    {31'b0, imemREN},  32'h0);
    check_eq("halt_pipe",   {31'b0, pipe1_en}, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("halt_flush",  {31'b0, flush_o}, 32'h1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("resume_halted", {31'b0, halted},   32'h0);
    check_eq("resume_addr",   imemaddr,          32'h0);
    check_eq("resume_ren",    {31'b0, imemREN},  32'h1);
    check_eq("resume_pipe",   {31'b0, pipe1_en}, 32'h1);
    tick();
`else
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("nohalt_halted", {31'b0, halted},  32'h0);
    check_eq("nohalt_ren",    {31'b0, imemREN}, 32'h1);
    check_eq("nohalt_addr",   imemaddr,         32'hC);
`endif

    // Reset while squashing drops the pending target.
    goto_pc(32'h60);
    drive(1'b0, 1'b0, 1'b1, 32'h500);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    nRST = 1'b0;
    #1;
    check_eq("rsq_addr", imemaddr, 32'h0);
    check_eq("rsq_ren",  {31'b0, imemREN}, 32'h0);
    tick();
    nRST = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("rsq_rel_addr", imemaddr, 32'h0);
    check_eq("rsq_rel_pipe", {31'b0, pipe1_en}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("rsq_adv_addr", imemaddr, 32'h4);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
